// File: rtl/regfile_dump.sv
// Sweeps register-file indices FIRST_REG..LAST_REG through a combinational read port and
// streams each value over a valid/ready interface, keeping a running 32-bit checksum.
module regfile_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_addr,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
    localparam logic [4:0] LastIdx  = 5'(LAST_REG);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  index_q, index_d;
    logic [31:0] out_data_q, out_data_d;
    logic [4:0]  out_addr_q, out_addr_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] checksum_q, checksum_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            index_q     <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            checksum_q  <= checksum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        checksum_d  = checksum_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    index_d    = FirstIdx;
                    checksum_d = '0;
                    state_d    = StRead;
                end
            end
            StRead: begin
                // x0 is architecturally zero, whatever the read port returns
                out_data_d  = (index_q == 5'd0) ? 32'd0 : rd_data;
                out_addr_d  = index_q;
                out_last_d  = (index_q == LastIdx);
                out_valid_d = 1'b1;
                state_d     = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    checksum_d  = checksum_q + out_data_q;
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        rd_addr = (state_q == StIdle) ? FirstIdx : index_q;
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign checksum  = checksum_q;

endmodule
